// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader
// Brief    : Walks the register-file read port and streams each register out
//            over valid/ready. Optional XOR checksum: REGFILE_DUMP_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index
`ifdef REGFILE_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] c_first_reg = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] c_last_reg  = ADDR_W'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_idx;
    logic [ADDR_W-1:0]  w_idx_next;
    logic               r_busy;
    logic               r_done;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic [ADDR_W-1:0]  r_out_index;
    logic               w_accept;

    assign w_accept = r_out_valid && out_ready;

    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next     = S_READ;
                    w_idx_next = c_first_reg;
                end
            end
            S_READ: begin
                w_next = S_HOLD;
            end
            S_HOLD: begin
                if (w_accept) begin
                    // Terminal compare precedes increment so LAST_REG at the top of the range never wraps
                    if (r_idx == c_last_reg) begin
                        w_next = S_FIN;
                    end else begin
                        w_next     = S_READ;
                        w_idx_next = r_idx + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_idx_next = c_first_reg;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_idx       <= c_first_reg;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_FIN);
            if (r_state == S_READ) begin
                r_out_valid <= 1'b1;
                r_out_data  <= rf_rd;
                r_out_index <= r_idx;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_checksum <= '0;
        end else if ((r_state == S_HOLD) && w_accept) begin
            r_checksum <= r_checksum ^ r_out_data;
        end
    end

    assign checksum = r_checksum;
`endif

    assign rf_ra     = (r_state == S_IDLE) ? '0 : r_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_reader
// Brief    : Table-driven and randomized self-checking bench for the dump reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, start, out_ready, start8, ready8;
    logic          busy, done, out_valid, busy8, done8, valid8;
    logic [AW-1:0] rf_ra, out_index, rf_ra8, index8;
    logic [DW-1:0] rf_rd, out_data, rf_rd8, data8;
    logic [DW-1:0] rf [32];
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DW-1:0] checksum, checksum8;
`endif

    // Behavioural register file: combinational read, register 0 hard-wired to zero
    assign rf_rd  = (rf_ra  == '0) ? '0 : rf[rf_ra];
    assign rf_rd8 = (rf_ra8 == '0) ? '0 : rf[rf_ra8];

    regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0), .LAST_REG(31)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index)
`ifdef REGFILE_DUMP_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(8), .LAST_REG(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .busy(busy8), .done(done8),
        .rf_ra(rf_ra8), .rf_rd(rf_rd8), .out_valid(valid8), .out_ready(ready8),
        .out_data(data8), .out_index(index8)
`ifdef REGFILE_DUMP_CHECKSUM_EN
        , .checksum(checksum8)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // pattern: 0 = A5A5_0000+i, 1 = random, 2 = i, 3 = i with rf[1]=FFFF_FFFF
    typedef struct {
        int          pattern;
        int          stall_idx;
        int          stall_len;
        int          restart_idx;
        bit          rnd_ready;
        int          exp_words;
        bit          cksum_known;
        logic [31:0] exp_cksum;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [31:0] model_word(input int i);
        return (i == 0) ? 32'h0 : rf[i];
    endfunction

    task automatic run_dump(input vec_t v);
        int          q_idx[$];
        logic [31:0] q_dat[$];
        int          waits = 0, done_c = -1, stall = 0, n_exp;
        bit          busy_ok = 1, stable_ok = 1, restarted = 0, finished = 0;
        logic        pv = 0, pacc = 0;
        logic [31:0] pd = '0;
        logic [AW-1:0] pi = '0;
        logic [31:0] x;

        for (int i = 0; i < 32; i++) begin
            case (v.pattern)
                0:       rf[i] = 32'hA5A5_0000 + 32'(i);
                1:       rf[i] = $urandom;
                default: rf[i] = 32'(i);
            endcase
        end
        if (v.pattern == 3) rf[1] = 32'hFFFF_FFFF;

        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 3000 && !finished; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_c >= 0) begin
                chk("busy_after_done", {31'b0, busy}, 32'h0);
                finished = 1;
            end else begin
                if (!busy) busy_ok = 0;
                if (pv && !pacc && (!out_valid || out_data !== pd || out_index !== pi)) stable_ok = 0;
                if (done) done_c = c;
                if (out_valid && int'(out_index) == v.restart_idx && !restarted) begin
                    start = 1'b1;
                    restarted = 1;
                end
                out_ready = v.rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (out_valid && int'(out_index) == v.stall_idx && stall < v.stall_len) begin
                    out_ready = 1'b0;
                    stall++;
                end
                if (out_valid && !out_ready) waits++;
                if (out_valid && out_ready) begin
                    q_idx.push_back(int'(out_index));
                    q_dat.push_back(out_data);
                end
                pv = out_valid; pacc = out_valid && out_ready; pd = out_data; pi = out_index;
            end
        end
        out_ready = 1'b0;
        if (!finished) begin
            errors++; checks++;
            $display("FAIL dump_timeout: got no done, expected done within budget");
        end

        n_exp = v.exp_words;
        chk("word_count", 32'(q_idx.size()), 32'(n_exp));
        chk("busy_during_dump", {31'b0, busy_ok}, 32'h1);
        chk("held_word_stable", {31'b0, stable_ok}, 32'h1);
        // Each word costs a READ cycle plus an accept cycle, plus every back-pressured cycle
        chk("done_latency", 32'(done_c), 32'(2 * n_exp + waits));
        x = '0;
        for (int i = 0; i < n_exp && i < q_idx.size(); i++) begin
            chk($sformatf("index[%0d]", i), 32'(q_idx[i]), 32'(i));
            chk($sformatf("data[%0d]", i), q_dat[i], model_word(i));
            x ^= model_word(i);
        end
        if (v.pattern == 0 && q_dat.size() > 5) begin
            chk("word0_zero", q_dat[0], 32'h0);
            chk("word5", q_dat[5], 32'hA5A5_0005);
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        chk("checksum_model", checksum, x);
        if (v.cksum_known) chk("checksum_const", checksum, v.exp_cksum);
`endif
    endtask

    initial begin
        vecs[0] = '{0, -1, 0, -1, 1'b0, 32, 1'b0, 32'h0};
        vecs[1] = '{0,  7, 3, -1, 1'b0, 32, 1'b0, 32'h0};
        vecs[2] = '{0, -1, 0, 10, 1'b0, 32, 1'b0, 32'h0};
        vecs[3] = '{1, -1, 0, -1, 1'b1, 32, 1'b0, 32'h0};
        vecs[4] = '{1,  3, 4, 20, 1'b1, 32, 1'b0, 32'h0};
        vecs[5] = '{2, -1, 0, -1, 1'b0, 32, 1'b1, 32'h0000_0000};
        vecs[6] = '{3, -1, 0, -1, 1'b1, 32, 1'b1, 32'hFFFF_FFFE};

        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; start8 = 1'b0; ready8 = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i);
        repeat (3) @(negedge clk);
        chk("rst_busy",      {31'b0, busy},      32'h0);
        chk("rst_done",      {31'b0, done},      32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_data",  out_data,           32'h0);
        chk("rst_out_index", 32'(out_index),     32'h0);
        chk("rst_rf_ra",     32'(rf_ra),         32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 7; t++) run_dump(vecs[t]);

        // Reset while holding index 12: outputs clear asynchronously, next dump restarts at 0
        @(negedge clk);
        start = 1'b1;
        begin
            bit hit = 0;
            for (int c = 0; c < 200 && !hit; c++) begin
                @(negedge clk);
                start = 1'b0;
                out_ready = !(out_valid && out_index == AW'(12));
                if (out_valid && out_index == AW'(12)) hit = 1;
            end
            chk("reached_idx12", {31'b0, hit}, 32'h1);
        end
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_busy",  {31'b0, busy},      32'h0);
        chk("async_rst_done",  {31'b0, done},      32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        run_dump(vecs[0]);

        // Single-register range: one word, done two cycles after the start edge
        rf[8] = 32'hDEAD_BEEF;
        ready8 = 1'b1;
        @(negedge clk);
        start8 = 1'b1;
        begin
            int nw = 0, dc = -1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                start8 = 1'b0;
                if (valid8) begin
                    nw++;
                    chk("r8_index", 32'(index8), 32'd8);
                    chk("r8_data", data8, 32'hDEAD_BEEF);
                end
                if (done8 && dc < 0) dc = c;
            end
            chk("r8_words", 32'(nw), 32'd1);
            chk("r8_done_cycle", 32'(dc), 32'd2);
        end

        // Start held high: IDLE is visited for exactly one cycle between dumps
        @(negedge clk);
        start8 = 1'b1;
        begin
            logic [5:0] bz;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                bz[c] = busy8;
            end
            chk("held_start_busy", {26'b0, bz}, 32'b110111);
        end
        start8 = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
